// File: rtl/out_fifo_wr_sched_if.sv
// Requester-side and OUT_FIFO-side signals of the write scheduler.
// wr_count exists only when OUT_FIFO_WR_SCHED_STATS_EN is defined.
interface out_fifo_wr_sched_if #(
   parameter int unsigned NREQ = 4
);
   logic [NREQ-1:0]    req_valid;
   logic [NREQ*80-1:0] req_data;
   logic [NREQ-1:0]    req_ready;
   logic               fifo_almostfull;
   logic               fifo_full;
   logic               fifo_wren;
   logic [79:0]        fifo_d;
   logic [2:0]         grant_id;
   logic               busy;
`ifdef OUT_FIFO_WR_SCHED_STATS_EN
   logic [15:0]        wr_count;

   modport master (
      input  req_valid, req_data, fifo_almostfull, fifo_full,
      output req_ready, fifo_wren, fifo_d, grant_id, busy, wr_count
   );
   modport slave (
      output req_valid, req_data, fifo_almostfull, fifo_full,
      input  req_ready, fifo_wren, fifo_d, grant_id, busy, wr_count
   );
`else
   modport master (
      input  req_valid, req_data, fifo_almostfull, fifo_full,
      output req_ready, fifo_wren, fifo_d, grant_id, busy
   );
   modport slave (
      output req_valid, req_data, fifo_almostfull, fifo_full,
      input  req_ready, fifo_wren, fifo_d, grant_id, busy
   );
`endif
endinterface

// File: rtl/out_fifo_wr_sched.sv
// Round-robin burst scheduler sharing one 80-bit OUT_FIFO write port among NREQ requesters.
// Define OUT_FIFO_WR_SCHED_STATS_EN to add the saturating wr_count statistic.
module out_fifo_wr_sched #(
   parameter int unsigned NREQ      = 4,
   parameter int unsigned MAX_BURST = 8
) (
   input logic                 clk,
   input logic                 rst_n,
   out_fifo_wr_sched_if.master bus
);
   localparam int unsigned DW = 80;
   localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int unsigned CW = $clog2(MAX_BURST + 1);

   typedef enum logic {IDLE, BURST} state_t;

   state_t          state_q, state_d;
   logic [IW-1:0]   rr_q, rr_d;
   logic [IW-1:0]   gnt_q, gnt_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [IW-1:0]   cand_c;
   logic            found_c;
   logic            room_c;
   logic            xfer_c;
   logic [NREQ-1:0] ready_c;
   logic [DW-1:0]   word_c;

   // Word of the current grant holder
   always_comb begin
      word_c = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         if (gnt_q == IW'(i)) word_c = bus.req_data[DW*i +: DW];
      end
   end

   // Arbitration and burst control
   always_comb begin
      state_d = state_q;
      rr_d    = rr_q;
      gnt_d   = gnt_q;
      cnt_d   = cnt_q;
      cand_c  = '0;
      found_c = 1'b0;
      ready_c = '0;
      xfer_c  = 1'b0;
      room_c  = ~bus.fifo_almostfull & ~bus.fifo_full;
      case (state_q)
         IDLE: begin
            for (int unsigned off = 1; off <= NREQ; off++) begin
               cand_c = IW'((32'(rr_q) + off) % NREQ);
               if (!found_c && bus.req_valid[cand_c]) begin
                  found_c = 1'b1;
                  gnt_d   = cand_c;
               end
            end
            if (found_c) begin
               cnt_d   = '0;
               state_d = BURST;
            end
         end
         BURST: begin
            ready_c[gnt_q] = room_c;
            xfer_c         = bus.req_valid[gnt_q] & room_c;
            if (!bus.req_valid[gnt_q]) begin
               state_d = IDLE;
               rr_d    = gnt_q;
            end else if (xfer_c) begin
               cnt_d = cnt_q + CW'(1);
               if (cnt_d == CW'(MAX_BURST)) begin
                  state_d = IDLE;
                  rr_d    = gnt_q;
               end
            end
         end
      endcase
   end

   assign bus.req_ready = ready_c;
   assign bus.grant_id  = 3'(gnt_q);

   // State and registered write stage; reset drops any pending write
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         rr_q          <= IW'(NREQ - 1);
         gnt_q         <= '0;
         cnt_q         <= '0;
         bus.busy      <= 1'b0;
         bus.fifo_wren <= 1'b0;
         bus.fifo_d    <= '0;
      end else begin
         state_q       <= state_d;
         rr_q          <= rr_d;
         gnt_q         <= gnt_d;
         cnt_q         <= cnt_d;
         bus.busy      <= (state_d == BURST);
         bus.fifo_wren <= xfer_c;
         if (xfer_c) bus.fifo_d <= word_c;
      end
   end

`ifdef OUT_FIFO_WR_SCHED_STATS_EN
   // Saturating count of issued writes
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.wr_count <= '0;
      end else if (bus.fifo_wren && (bus.wr_count != 16'hFFFF)) begin
         bus.wr_count <= bus.wr_count + 16'd1;
      end
   end
`endif
endmodule

// File: tb/tb_out_fifo_wr_sched.sv
// Bench for out_fifo_wr_sched: per-cycle model comparison plus directed scenario checks.
module tb_out_fifo_wr_sched;
   localparam int NREQ = 4;
   localparam int MAXB = 8;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   out_fifo_wr_sched_if #(.NREQ(NREQ)) bus ();
   out_fifo_wr_sched #(.NREQ(NREQ), .MAX_BURST(MAXB)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;
   int remaining [NREQ];
   int seq       [NREQ];
   int wcyc [$];
   int wid  [$];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   function automatic logic [79:0] word_of(input int i, input int s);
      return {8'(i), 16'(s), 56'(32'hC0DE0000 + 32'(i * 256 + s))};
   endfunction

   task automatic apply();
      for (int i = 0; i < NREQ; i++) begin
         bus.req_valid[i]           = (remaining[i] > 0);
         bus.req_data[80*i +: 80]   = word_of(i, seq[i]);
      end
   endtask

   // Reference: a grant holder (-1 when none), words in its burst, last holder
   int          m_hold, m_cnt, m_last, m_wrc;
   logic        m_wren, m_x;
   logic [79:0] m_d;
   logic [2:0]  m_gid;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_hold = -1; m_cnt = 0; m_last = NREQ - 1; m_wrc = 0;
         m_wren = 1'b0; m_d = '0; m_gid = '0;
      end else begin
         if (m_wren && m_wrc < 65535) m_wrc++;
         m_x = (m_hold >= 0) && bus.req_valid[m_hold] && !bus.fifo_almostfull && !bus.fifo_full;
         m_wren = m_x;
         if (m_x) m_d = bus.req_data[80*m_hold +: 80];
         if (m_hold < 0) begin
            for (int k = 1; k <= NREQ; k++) begin
               if (m_hold < 0 && bus.req_valid[(m_last + k) % NREQ]) begin
                  m_hold = (m_last + k) % NREQ;
                  m_cnt  = 0;
                  m_gid  = 3'(m_hold);
               end
            end
         end else if (!bus.req_valid[m_hold]) begin
            m_last = m_hold; m_hold = -1;
         end else if (m_x) begin
            m_cnt++;
            if (m_cnt == MAXB) begin m_last = m_hold; m_hold = -1; end
         end
      end
   end

   // Per-cycle comparison against the reference, plus a write log
   always @(negedge clk) begin
      logic [NREQ-1:0] er;
      er = '0;
      if (m_hold >= 0 && !bus.fifo_almostfull && !bus.fifo_full) er[m_hold] = 1'b1;
      chk("req_ready", 80'(bus.req_ready), 80'(er));
      chk("fifo_wren", 80'(bus.fifo_wren), 80'(m_wren));
      chk("fifo_d", bus.fifo_d, m_d);
      chk("busy", 80'(bus.busy), 80'(m_hold >= 0));
      if (m_hold >= 0) chk("grant_id", 80'(bus.grant_id), 80'(m_gid));
`ifdef OUT_FIFO_WR_SCHED_STATS_EN
      chk("wr_count", 80'(bus.wr_count), 80'(m_wrc));
`endif
      if (bus.fifo_wren) begin
         wcyc.push_back(cyc);
         wid.push_back(int'(bus.fifo_d[79:72]));
      end
   end

   task automatic step();
      logic [NREQ-1:0] acc;
      @(negedge clk);
      acc = bus.req_ready & bus.req_valid;
      @(posedge clk);
      #2;
      for (int i = 0; i < NREQ; i++) begin
         if (acc[i]) begin remaining[i]--; seq[i]++; end
      end
      apply();
   endtask

   task automatic drain(input int budget, input string nm);
      int n;
      bit pend;
      n = 0;
      pend = 1'b1;
      while (pend && n < budget) begin
         pend = bus.busy || bus.fifo_wren;
         for (int i = 0; i < NREQ; i++) if (remaining[i] > 0) pend = 1'b1;
         if (pend) begin step(); n++; end
      end
      n_cmp++;
      if (pend) begin
         n_bad++;
         $display("FAIL %s: timeout after %0d cycles, required completion", nm, n);
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      bus.fifo_almostfull = 1'b0;
      bus.fifo_full = 1'b0;
      for (int i = 0; i < NREQ; i++) begin remaining[i] = 0; seq[i] = 0; end
      apply();
      repeat (2) @(posedge clk);
      #2;
      rst_n = 1'b1;
      wcyc.delete();
      wid.delete();
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int st;
      int exp_rr [5];
      exp_rr = '{0, 1, 2, 3, 0};

      rst_n = 1'b0;
      bus.fifo_almostfull = 1'b0;
      bus.fifo_full = 1'b0;
      for (int i = 0; i < NREQ; i++) begin remaining[i] = 0; seq[i] = 0; end
      apply();
      #1;
      chk("reset_wren", 80'(bus.fifo_wren), 80'(0));
      chk("reset_busy", 80'(bus.busy), 80'(0));
      chk("reset_d", bus.fifo_d, 80'(0));
      chk("reset_gid", 80'(bus.grant_id), 80'(0));
      chk("reset_ready", 80'(bus.req_ready), 80'(0));

      // Single requester: split at MAX_BURST with one bubble
      do_reset();
      st = cyc;
      remaining[0] = 10;
      apply();
      drain(60, "single");
      chk("single_writes", 80'(wcyc.size()), 80'(10));
      if (wcyc.size() == 10) begin
         chk("single_latency", 80'(wcyc[0] - st), 80'(2));
         chk("single_burst", 80'(wcyc[7] - wcyc[0]), 80'(7));
         chk("single_bubble", 80'(wcyc[8] - wcyc[7]), 80'(2));
         chk("single_tail", 80'(wcyc[9] - wcyc[8]), 80'(1));
         chk("single_id", 80'(wid[9]), 80'(0));
      end

      // Round-robin over all requesters
      do_reset();
      remaining[0] = 16; remaining[1] = 8; remaining[2] = 8; remaining[3] = 8;
      apply();
      drain(100, "rr");
      chk("rr_writes", 80'(wcyc.size()), 80'(40));
      if (wcyc.size() == 40) begin
         for (int b = 0; b < 5; b++) begin
            chk("rr_first_id", 80'(wid[8*b]), 80'(exp_rr[b]));
            chk("rr_last_id", 80'(wid[8*b+7]), 80'(exp_rr[b]));
         end
         for (int b = 0; b < 4; b++) chk("rr_bubble", 80'(wcyc[8*b+8] - wcyc[8*b+7]), 80'(2));
      end

      // Almost-full throttle for 5 cycles after word 3
      do_reset();
      remaining[0] = 8;
      apply();
      for (int n = 0; n < 20 && seq[0] < 3; n++) step();
      bus.fifo_almostfull = 1'b1;
      repeat (5) step();
      bus.fifo_almostfull = 1'b0;
      drain(40, "throttle");
      chk("thr_writes", 80'(wcyc.size()), 80'(8));
      if (wcyc.size() == 8) begin
         chk("thr_gap", 80'(wcyc[3] - wcyc[2]), 80'(6));
         chk("thr_resume", 80'(wcyc[7] - wcyc[3]), 80'(4));
         chk("thr_id", 80'(wid[7]), 80'(0));
      end

      // Full flag stall for 2 cycles after word 1
      do_reset();
      remaining[3] = 3;
      apply();
      step(); step();
      bus.fifo_full = 1'b1;
      step(); step();
      bus.fifo_full = 1'b0;
      drain(30, "full");
      chk("full_writes", 80'(wcyc.size()), 80'(3));
      if (wcyc.size() == 3) chk("full_gap", 80'(wcyc[1] - wcyc[0]), 80'(3));

      // Early release, requester 3 next
      do_reset();
      remaining[2] = 2; remaining[3] = 1;
      apply();
      drain(30, "early_a");
      chk("early_a_writes", 80'(wcyc.size()), 80'(3));
      if (wcyc.size() == 3) begin
         chk("early_a_id0", 80'(wid[0]), 80'(2));
         chk("early_a_next", 80'(wid[2]), 80'(3));
         chk("early_a_gap", 80'(wcyc[2] - wcyc[1]), 80'(3));
      end

      // Early release, requester 0 next when 3 is idle
      do_reset();
      remaining[2] = 2;
      apply();
      step();
      remaining[0] = 1;
      apply();
      drain(30, "early_b");
      chk("early_b_writes", 80'(wcyc.size()), 80'(3));
      if (wcyc.size() == 3) begin
         chk("early_b_id0", 80'(wid[0]), 80'(2));
         chk("early_b_next", 80'(wid[2]), 80'(0));
      end

      // Reset mid-burst while a write is on the port
      do_reset();
      remaining[1] = 8;
      apply();
      for (int n = 0; n < 10 && !bus.fifo_wren; n++) step();
      chk("pre_rst_wren", 80'(bus.fifo_wren), 80'(1));
      rst_n = 1'b0;
      #1;
      chk("rst_wren", 80'(bus.fifo_wren), 80'(0));
      chk("rst_busy", 80'(bus.busy), 80'(0));
`ifdef OUT_FIFO_WR_SCHED_STATS_EN
      chk("rst_wr_count", 80'(bus.wr_count), 80'(0));
`endif
      remaining[0] = 2; remaining[1] = 8;
      apply();
      @(posedge clk);
      #2;
      rst_n = 1'b1;
      wcyc.delete();
      wid.delete();
      drain(60, "post_rst");
      chk("post_rst_writes", 80'(wcyc.size()), 80'(10));
      if (wcyc.size() > 0) chk("post_rst_first", 80'(wid[0]), 80'(0));

`ifdef OUT_FIFO_WR_SCHED_STATS_EN
      // Counter saturation
      do_reset();
      remaining[0] = 65600;
      apply();
      drain(80000, "stats");
      chk("wr_count_sat", 80'(bus.wr_count), 80'(65535));
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
